mem_port_arbiter: RTL and testbench

Two-requester round-robin arbiter for the single shared memory port of the CPU datapath. Requester 0 is instruction fetch and requester 1 is data load/store. The block owns the select of the address/write-data 2:1 steering mux in front of memory. It sequences one transaction at a time, returns the response to the owner, and aborts a transaction if memory never acknowledges it.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter for the shared memory
// port. Requester 0 is instruction fetch, requester 1 is data load/store.
// One transaction at a time; each ends on a memory ack or on a timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              sel_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic busy;
    logic acked;
    logic timed_out;
    logic done;

    // 2:1 steering of the address bus; zero while the port is not owned.
    function automatic logic [ADDR_W-1:0] steer_addr(
        input logic              en,
        input logic              sel,
        input logic [ADDR_W-1:0] a0,
        input logic [ADDR_W-1:0] a1
    );
        if (!en)
            return '0;
        return sel ? a1 : a0;
    endfunction

    // 2:1 steering of the write-data bus; zero while the port is not owned.
    function automatic logic [DATA_W-1:0] steer_data(
        input logic              en,
        input logic              sel,
        input logic [DATA_W-1:0] d0,
        input logic [DATA_W-1:0] d1
    );
        if (!en)
            return '0;
        return sel ? d1 : d0;
    endfunction

    assign busy      = (state_q == S_BUSY);
    assign acked     = busy & mem_ack_i;
    // A coincident ack wins over the timeout, so the timeout requires no ack.
    assign timed_out = busy & ~mem_ack_i & (cnt_q == CNT_LAST);
    assign done      = acked | timed_out;

    // Next-state: arbitrate in IDLE, count and finish in BUSY.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0_i | req1_i) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    // On a tie the requester not served last wins.
                    if (req0_i & req1_i)
                        owner_d = ~last_q;
                    else
                        owner_d = req1_i;
                end
            end
            default: begin
                if (done) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; reset drops any transaction in flight without an ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grants and the mux select come straight from registered state;
    // sel_o keeps pointing at the last owner while idle.
    assign gnt0_o    = busy & ~owner_q;
    assign gnt1_o    = busy &  owner_q;
    assign sel_o     = owner_q;
    assign mem_req_o = busy;

    assign mem_addr_o  = steer_addr(busy, owner_q, addr0_i, addr1_i);
    assign mem_wdata_o = steer_data(busy, owner_q, wdata0_i, wdata1_i);
    assign mem_we_o    = busy & (owner_q ? we1_i : we0_i);

    // Completion goes to the owner on ack or timeout; data only on a real ack.
    assign ack0_o  = done & ~owner_q;
    assign ack1_o  = done &  owner_q;
    assign err_o   = timed_out;
    assign rdata_o = acked ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven bench for mem_port_arbiter
// built with TIMEOUT = 4, plus hand-written reset sequences.
module tb_mem_port_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0040;
    localparam logic [31:0] W0 = 32'h0000_0011;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] W1 = 32'h0000_0055;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        ack0;
        logic        ack1;
        logic        err;
        logic        sel;
        logic        mreq;
        logic        mwe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } out_t;

    typedef struct {
        logic        req0;
        logic        req1;
        logic        ack;
        logic [31:0] mrdata;
        bit          bus;   // port owned: address/write-data buses are checked
        out_t        exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_i, req1_i, we0_i, we1_i, mem_ack_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i;
    logic        gnt0_o, gnt1_o, ack0_o, ack1_o, err_o, sel_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;

    out_t act;
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req0_i      (req0_i),
        .req1_i      (req1_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .we0_i       (we0_i),
        .we1_i       (we1_i),
        .gnt0_o      (gnt0_o),
        .gnt1_o      (gnt1_o),
        .ack0_o      (ack0_o),
        .ack1_o      (ack1_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .sel_o       (sel_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    assign act = {gnt0_o, gnt1_o, ack0_o, ack1_o, err_o, sel_o, mem_req_o, mem_we_o,
                  mem_addr_o, mem_wdata_o, rdata_o};

    function automatic out_t o(input bit g0, input bit g1, input bit a0, input bit a1,
                               input bit e, input bit s, input bit mr, input bit mw,
                               input logic [31:0] ad, input logic [31:0] wd,
                               input logic [31:0] rd);
        out_t r;
        r = {g0, g1, a0, a1, e, s, mr, mw, ad, wd, rd};
        return r;
    endfunction

    // Idle cycle: nothing asserted, select holding the given value.
    function automatic out_t idle(input bit s);
        return o(0, 0, 0, 0, 0, s, 0, 0, 32'h0, 32'h0, 32'h0);
    endfunction

    task automatic add(input logic r0, input logic r1, input logic ak,
                       input logic [31:0] mrd, input bit bus, input out_t e);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.ack = ak; v.mrdata = mrd; v.bus = bus; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input bit bus, input out_t e);
        out_t a;
        out_t x;
        a = act;
        x = e;
        if (!bus) begin
            a.addr = '0; a.wdata = '0;
            x.addr = '0; x.wdata = '0;
        end
        n_vec++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, a, x);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        req0_i = 1'b1; req1_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        addr0_i = A0; wdata0_i = W0; we0_i = 1'b0;
        addr1_i = A1; wdata1_i = W1; we1_i = 1'b1;

        // Vector table: one row per clock cycle, starting right after reset release.
        add(0, 0, 0, 32'h0,         0, idle(0));
        add(1, 0, 0, 32'h0,         0, idle(0));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 1, 32'hDEADBEEF,  1, o(1,0,1,0,0,0,1,0, A0, W0, 32'hDEADBEEF));
        add(0, 0, 0, 32'h0,         0, idle(0));
        add(0, 1, 0, 32'h0,         0, idle(0));
        add(0, 1, 0, 32'h0,         1, o(0,1,0,0,0,1,1,1, A1, W1, 32'h0));
        add(0, 0, 1, 32'h12345678,  1, o(0,1,0,1,0,1,1,1, A1, W1, 32'h12345678));
        add(0, 0, 1, 32'hAAAA5555,  0, idle(1));
        add(0, 0, 0, 32'h0,         0, idle(1));
        add(1, 1, 0, 32'h0,         0, idle(1));
        add(1, 1, 1, 32'h0000000A,  1, o(1,0,1,0,0,0,1,0, A0, W0, 32'h0000000A));
        add(1, 1, 0, 32'h0,         0, idle(0));
        add(1, 1, 1, 32'h0000000B,  1, o(0,1,0,1,0,1,1,1, A1, W1, 32'h0000000B));
        add(1, 1, 0, 32'h0,         0, idle(1));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 0, 32'hFFFFFFFF,  1, o(1,0,1,0,1,0,1,0, A0, W0, 32'h0));
        add(1, 0, 0, 32'h0,         0, idle(0));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 0, 32'h0,         1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        add(1, 0, 1, 32'h00C0FFEE,  1, o(1,0,1,0,0,0,1,0, A0, W0, 32'h00C0FFEE));
        add(0, 0, 0, 32'h0,         0, idle(0));

        // Reset held with a request and a memory ack present: everything zero.
        repeat (2) @(posedge clk_i);
        #1 chk("reset_state", 1, idle(0));

        req0_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        rst_i = 1'b1;

        foreach (vecs[i]) begin
            req0_i = vecs[i].req0;
            req1_i = vecs[i].req1;
            mem_ack_i = vecs[i].ack;
            mem_rdata_i = vecs[i].mrdata;
            #4 chk($sformatf("vec%0d", i), vecs[i].bus, vecs[i].exp);
            @(posedge clk_i);
            #1;
        end

        // Reset in the middle of a requester-1 transaction.
        req0_i = 1'b0; req1_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = '0;
        @(posedge clk_i);
        #1 chk("rst_pre_busy", 1, o(0,1,0,0,0,1,1,1, A1, W1, 32'h0));
        #2;
        req0_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
        rst_i = 1'b0;
        #1 chk("rst_async_clear", 1, idle(0));
        @(posedge clk_i);
        #1 chk("rst_held", 1, idle(0));
        // Release with both requesting: requester 0 must win the first tie.
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        rst_i = 1'b1;
        #4 chk("rst_release_idle", 0, idle(0));
        @(posedge clk_i);
        #1 chk("rst_first_grant", 1, o(1,0,0,0,0,0,1,0, A0, W0, 32'h0));
        req0_i = 1'b0; req1_i = 1'b0;
        repeat (2) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
